tia_phase_gen: RTL and testbench

//  Generates the two-phase strobes (s1, s2) that drive chains of tia_d1 delay

---
 rtl/tia_phase_gen_if.sv | 27 ++
 rtl/tia_phase_gen.sv | 82 ++++++++
 tb/tb_tia_phase_gen.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tia_phase_gen_if.sv
// Control and strobe bundle for the two-phase strobe generator.
// The master side drives the controls; the slave side drives the strobes.
interface tia_phase_gen_if #(
  parameter int DIVIDE  = 4,
  parameter int EXTRA_W = 4
);
  localparam int PW = $clog2(DIVIDE);

  logic               resync;
  logic               hold;
  logic               extra_req;
  logic [EXTRA_W-1:0] extra_cnt;
  logic               s1;
  logic               s2;
  logic [PW-1:0]      phase;
  logic               busy;

  modport master (
    output resync, hold, extra_req, extra_cnt,
    input  s1, s2, phase, busy
  );

  modport slave (
    input  resync, hold, extra_req, extra_cnt,
    output s1, s2, phase, busy
  );
endinterface

// File: rtl/tia_phase_gen.sv
// Two-phase strobe generator for chains of delay stages.
// A phase counter walks 0..DIVIDE-1; s1 fires after leaving phase 0 and s2
// after leaving PHI2_PHASE. Hold freezes the counter, except while a burst
// of extra periods is pending, which is drained one period per wrap.
module tia_phase_gen #(
  parameter int DIVIDE     = 4,
  parameter int PHI2_PHASE = DIVIDE / 2,
  parameter int EXTRA_W    = 4
) (
  input logic           clk,
  input logic           rst_n,
  tia_phase_gen_if.slave bus
);
  localparam int PW = $clog2(DIVIDE);
  localparam logic [PW-1:0]      PHASE_LAST = PW'(DIVIDE - 1);
  localparam logic [PW-1:0]      PHASE_PHI2 = PW'(PHI2_PHASE);
  localparam logic [PW-1:0]      PHASE_ZERO = '0;
  localparam logic [PW-1:0]      PHASE_ONE  = PW'(1);
  localparam logic [EXTRA_W-1:0] PEND_ZERO  = '0;
  localparam logic [EXTRA_W-1:0] PEND_ONE   = EXTRA_W'(1);

  logic [PW-1:0]      phase_q, phase_d;
  logic [EXTRA_W-1:0] pending_q, pending_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               busy_q, busy_d;
  logic               advance;
  logic               pending_nz;

  assign pending_nz = (pending_q != PEND_ZERO);
  // Pending extras override hold, so a frozen chain can still be clocked.
  assign advance    = !bus.hold || pending_nz;

  // Next-state: resync beats everything, then the extra load, then stepping.
  always_comb begin
    phase_d   = phase_q;
    pending_d = pending_q;
    s1_d      = 1'b0;
    s2_d      = 1'b0;
    if (bus.resync) begin
      phase_d   = PHASE_ZERO;
      pending_d = PEND_ZERO;
    end else begin
      if (advance) begin
        phase_d = (phase_q == PHASE_LAST) ? PHASE_ZERO : phase_q + PHASE_ONE;
        s1_d    = (phase_q == PHASE_ZERO);
        s2_d    = (phase_q == PHASE_PHI2);
      end
      // A new burst is only accepted when idle; a load wins over a decrement.
      // Decrement only counts periods run while frozen, so free-running
      // periods never consume extras.
      if (bus.extra_req && !pending_nz) begin
        pending_d = bus.extra_cnt;
      end else if (advance && bus.hold && (phase_q == PHASE_LAST)) begin
        pending_d = pending_q - PEND_ONE;
      end
    end
    busy_d = (pending_d != PEND_ZERO);
  end

  // State register with immediate clear on reset assertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PHASE_ZERO;
      pending_q <= PEND_ZERO;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      pending_q <= pending_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.s1    = s1_q;
  assign bus.s2    = s2_q;
  assign bus.phase = phase_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_tia_phase_gen.sv
// Directed bench for tia_phase_gen with DIVIDE=4, PHI2_PHASE=2.
module tb_tia_phase_gen;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tia_phase_gen_if #(.DIVIDE(4), .EXTRA_W(4)) bus ();

  tia_phase_gen #(.DIVIDE(4), .PHI2_PHASE(2), .EXTRA_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.resync = 1'b0; bus.hold = 1'b0; bus.extra_req = 1'b0; bus.extra_cnt = '0;
    step();
    step();
    total++;
    if ({bus.s1, bus.s2, bus.busy, bus.phase} !== 5'b0) begin
      bad++; $display("FAIL reset_state got=%b want=00000", {bus.s1, bus.s2, bus.busy, bus.phase});
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      total++;
      if (bus.s1 !== (n % 4 == 1) || bus.s2 !== (n % 4 == 3) || bus.phase !== 2'(n % 4)) begin
        bad++;
        $display("FAIL free_run edge=%0d got s1=%b s2=%b ph=%0d want s1=%b s2=%b ph=%0d",
                 n, bus.s1, bus.s2, bus.phase, (n % 4 == 1), (n % 4 == 3), n % 4);
      end
    end
    $display("test_reset: free-run sequence checked");
  endtask

  task automatic test_hold();
    step(); step();
    total++;
    if (bus.phase !== 2'd2) begin
      bad++; $display("FAIL hold_setup got ph=%0d want 2", bus.phase);
    end
    bus.hold = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      total++;
      if (bus.s1 !== 1'b0 || bus.s2 !== 1'b0 || bus.phase !== 2'd2) begin
        bad++; $display("FAIL hold_frozen cyc=%0d got s1=%b s2=%b ph=%0d want 0 0 2",
                        n, bus.s1, bus.s2, bus.phase);
      end
    end
    bus.hold = 1'b0;
    step();
    total++;
    if (bus.s2 !== 1'b1 || bus.s1 !== 1'b0 || bus.phase !== 2'd3) begin
      bad++; $display("FAIL hold_resume_s2 got s1=%b s2=%b ph=%0d want 0 1 3", bus.s1, bus.s2, bus.phase);
    end
    step();
    total++;
    if (bus.s1 !== 1'b0 || bus.s2 !== 1'b0 || bus.phase !== 2'd0) begin
      bad++; $display("FAIL hold_resume_gap got s1=%b s2=%b ph=%0d want 0 0 0", bus.s1, bus.s2, bus.phase);
    end
    step();
    total++;
    if (bus.s1 !== 1'b1 || bus.phase !== 2'd1) begin
      bad++; $display("FAIL hold_resume_s1 got s1=%b ph=%0d want 1 1", bus.s1, bus.phase);
    end
    $display("test_hold: freeze and resume checked");
  endtask

  task automatic test_extra();
    int c1, c2;
    step(); step(); step();
    total++;
    if (bus.phase !== 2'd0) begin
      bad++; $display("FAIL extra_setup got ph=%0d want 0", bus.phase);
    end
    bus.hold = 1'b1; bus.extra_req = 1'b1; bus.extra_cnt = 4'd3;
    step();
    bus.extra_req = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.phase !== 2'd0 || bus.s1 !== 1'b0) begin
      bad++; $display("FAIL extra_load got busy=%b ph=%0d s1=%b want 1 0 0", bus.busy, bus.phase, bus.s1);
    end
    c1 = 0; c2 = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      c1 += int'(bus.s1); c2 += int'(bus.s2);
      total++;
      if (bus.s1 && bus.s2) begin
        bad++; $display("FAIL extra_overlap cyc=%0d got s1=s2=1 want never both", n);
      end
      if (n == 11) begin
        total++;
        if (bus.busy !== 1'b1) begin
          bad++; $display("FAIL extra_busy_mid got busy=%b want 1", bus.busy);
        end
      end
    end
    total++;
    if (c1 != 3 || c2 != 3 || bus.busy !== 1'b0 || bus.phase !== 2'd0) begin
      bad++; $display("FAIL extra_burst got s1=%0d s2=%0d busy=%b ph=%0d want 3 3 0 0",
                      c1, c2, bus.busy, bus.phase);
    end
    step(); step();
    total++;
    if (bus.phase !== 2'd0 || bus.s1 !== 1'b0) begin
      bad++; $display("FAIL extra_after got ph=%0d s1=%b want 0 0", bus.phase, bus.s1);
    end
    bus.extra_req = 1'b1; bus.extra_cnt = 4'd0;
    step();
    bus.extra_req = 1'b0;
    step();
    total++;
    if (bus.busy !== 1'b0 || bus.phase !== 2'd0) begin
      bad++; $display("FAIL extra_zero got busy=%b ph=%0d want 0 0", bus.busy, bus.phase);
    end
    $display("test_extra: burst of 3 checked, cnt=0 no-op checked");
  endtask

  task automatic test_ignore_and_resync();
    int c1, c2, edges;
    bus.extra_req = 1'b1; bus.extra_cnt = 4'd5;
    step();
    bus.extra_req = 1'b0;
    c1 = 0; c2 = 0; edges = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 3) begin bus.extra_req = 1'b1; bus.extra_cnt = 4'd2; end
      step();
      edges = n;
      c1 += int'(bus.s1); c2 += int'(bus.s2);
      if (n == 3) begin
        bus.extra_req = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
          bad++; $display("FAIL ignore_busy got busy=%b want 1", bus.busy);
        end
      end
      if (!bus.busy) break;
    end
    total++;
    if (edges != 20 || c1 != 5 || c2 != 5 || bus.phase !== 2'd0) begin
      bad++; $display("FAIL ignore_burst got edges=%0d s1=%0d s2=%0d ph=%0d want 20 5 5 0",
                      edges, c1, c2, bus.phase);
    end
    bus.extra_req = 1'b1; bus.extra_cnt = 4'd5;
    step();
    bus.extra_req = 1'b0;
    for (int n = 0; n < 5; n++) step();
    bus.resync = 1'b1;
    step();
    bus.resync = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.phase !== 2'd0 || bus.s1 !== 1'b0 || bus.s2 !== 1'b0) begin
      bad++; $display("FAIL burst_resync got busy=%b ph=%0d s1=%b s2=%b want 0 0 0 0",
                      bus.busy, bus.phase, bus.s1, bus.s2);
    end
    for (int n = 0; n < 3; n++) begin
      step();
      total++;
      if (bus.s1 !== 1'b0 || bus.s2 !== 1'b0 || bus.phase !== 2'd0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL burst_stopped cyc=%0d got s1=%b s2=%b ph=%0d busy=%b want 0 0 0 0",
                        n, bus.s1, bus.s2, bus.phase, bus.busy);
      end
    end
    $display("test_ignore_and_resync: ignored request and mid-burst resync checked");
  endtask

  task automatic test_resync();
    bus.hold = 1'b0;
    step(); step(); step();
    total++;
    if (bus.phase !== 2'd3 || bus.s2 !== 1'b1) begin
      bad++; $display("FAIL resync_setup got ph=%0d s2=%b want 3 1", bus.phase, bus.s2);
    end
    bus.resync = 1'b1;
    step();
    bus.resync = 1'b0;
    total++;
    if (bus.s1 !== 1'b0 || bus.s2 !== 1'b0 || bus.phase !== 2'd0) begin
      bad++; $display("FAIL resync_edge got s1=%b s2=%b ph=%0d want 0 0 0", bus.s1, bus.s2, bus.phase);
    end
    step();
    total++;
    if (bus.s1 !== 1'b1 || bus.phase !== 2'd1) begin
      bad++; $display("FAIL resync_s1 got s1=%b ph=%0d want 1 1", bus.s1, bus.phase);
    end
    step();
    step();
    total++;
    if (bus.s2 !== 1'b1 || bus.s1 !== 1'b0 || bus.phase !== 2'd3) begin
      bad++; $display("FAIL resync_s2 got s1=%b s2=%b ph=%0d want 0 1 3", bus.s1, bus.s2, bus.phase);
    end
    $display("test_resync: phase restart checked");
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (bus.s2 !== 1'b1 && guard < 8) begin
      step();
      guard++;
    end
    total++;
    if (bus.s2 !== 1'b1) begin
      bad++; $display("FAIL areset_wait got s2=%b want 1 within 8 edges", bus.s2);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.s1, bus.s2, bus.busy, bus.phase} !== 5'b0) begin
      bad++; $display("FAIL areset_immediate got=%b want=00000", {bus.s1, bus.s2, bus.busy, bus.phase});
    end
    step();
    rst_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      total++;
      if (bus.s1 !== (n % 4 == 1) || bus.s2 !== (n % 4 == 3) || bus.phase !== 2'(n % 4)) begin
        bad++;
        $display("FAIL areset_rerun edge=%0d got s1=%b s2=%b ph=%0d want s1=%b s2=%b ph=%0d",
                 n, bus.s1, bus.s2, bus.phase, (n % 4 == 1), (n % 4 == 3), n % 4);
      end
    end
    $display("test_async_reset: immediate clear and rerun checked");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_hold();
    test_extra();
    test_ignore_and_resync();
    test_resync();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
